// File: rtl/ace_mem_uploader_if.sv
// Host upload and memory read signals of the ACE RAM uploader.
// master: uploader side; slave: host/memory side.
interface ace_mem_uploader_if;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [7:0]  ioctl_din;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ack;

  modport master (
    input  ioctl_upload, ioctl_rd, mem_data, mem_ack,
    output ioctl_din, mem_rd, mem_addr
  );

  modport slave (
    output ioctl_upload, ioctl_rd, mem_data, mem_ack,
    input  ioctl_din, mem_rd, mem_addr
  );
endinterface

// File: rtl/ace_mem_uploader.sv
// Streams Jupiter ACE RAM back to the host via a 2-entry prefetch FIFO.
// Ports: clk_sys, reset_n, bus (ioctl_*, mem_*), cpu_hold, busy, underrun.
// Option: ACE_UPLOAD_CKSUM_EN appends an XOR checksum byte.
module ace_mem_uploader #(
  parameter logic [15:0] BASE_ADDR   = 16'h2000,
  parameter logic [15:0] LENGTH      = 16'h6000,
  parameter int          HOLD_CYCLES = 8
) (
  input  logic clk_sys,
  input  logic reset_n,
  ace_mem_uploader_if.master bus,
  output logic cpu_hold,
  output logic busy,
  output logic underrun
);

  typedef enum logic [2:0] {
    IDLE, HOLD, FETCH, WAIT_ACK, DRAIN
  } state_e;

  localparam logic [16:0] LEN17 = {1'b0, LENGTH};
`ifdef ACE_UPLOAD_CKSUM_EN
  localparam logic [16:0] TOTAL = LEN17 + 17'd1;
`else
  localparam logic [16:0] TOTAL = LEN17;
`endif
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic        upl_q;
  logic [15:0] hcnt_q, hcnt_d;
  logic [16:0] fcnt_q, fcnt_d;
  logic [15:0] addr_q, addr_d;
  logic        und_q, und_d;
  logic        hold_q, hold_d;
  logic [7:0]  f0_q, f0_d;
  logic [7:0]  f1_q, f1_d;
  logic [1:0]  cnt_q, cnt_d;
`ifdef ACE_UPLOAD_CKSUM_EN
  logic [7:0]  ck_q, ck_d;
`endif

  logic       push, pop, empty, full, start;
  logic [7:0] pdata;

  assign empty = (cnt_q == 2'd0);
  assign full  = (cnt_q == 2'd2);
  assign start = bus.ioctl_upload && !upl_q;
  assign pop   = bus.ioctl_rd && !empty;

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    fcnt_d  = fcnt_q;
    addr_d  = addr_q;
    und_d   = und_q;
    push    = 1'b0;
    pdata   = bus.mem_data;
`ifdef ACE_UPLOAD_CKSUM_EN
    ck_d    = ck_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HOLD;
          hcnt_d  = '0;
          fcnt_d  = '0;
          addr_d  = BASE_ADDR;
          und_d   = 1'b0;
`ifdef ACE_UPLOAD_CKSUM_EN
          ck_d    = '0;
`endif
        end
      end
      HOLD: begin
        if (!bus.ioctl_upload) state_d = IDLE;
        else if (hcnt_q >= HOLD_LAST) state_d = FETCH;
        else hcnt_d = hcnt_q + 16'd1;
      end
      FETCH: begin
        if (!bus.ioctl_upload) begin
          state_d = IDLE;
        end else if (fcnt_q < LEN17) begin
          if (!full) state_d = WAIT_ACK;
`ifdef ACE_UPLOAD_CKSUM_EN
        end else if (fcnt_q == LEN17) begin
          if (!full) begin
            push   = 1'b1;
            pdata  = ck_q;
            fcnt_d = fcnt_q + 17'd1;
          end
`endif
        end else begin
          state_d = DRAIN;
        end
      end
      WAIT_ACK: begin
        // An aborted session still waits out the ack, then drops the byte.
        if (bus.mem_ack) begin
          if (!bus.ioctl_upload) begin
            state_d = IDLE;
          end else begin
            state_d = FETCH;
            push    = 1'b1;
            addr_d  = addr_q + 16'd1;
            fcnt_d  = fcnt_q + 17'd1;
`ifdef ACE_UPLOAD_CKSUM_EN
            ck_d    = ck_q ^ bus.mem_data;
`endif
          end
        end
      end
      DRAIN: begin
        if (!bus.ioctl_upload) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reads past the last byte are not underruns.
    if (bus.ioctl_rd && empty &&
        state_q != IDLE && fcnt_q != TOTAL)
      und_d = 1'b1;

    // Hold stays up for one cycle after IDLE is registered.
    hold_d = (state_d != IDLE) || (state_q != IDLE);
  end

  always_comb begin
    f0_d  = f0_q;
    f1_d  = f1_q;
    cnt_d = cnt_q;
    if (state_q != IDLE && state_d == IDLE) begin
      cnt_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (empty) f0_d = pdata;
          else f1_d = pdata;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          f0_d  = f1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            f0_d = pdata;
          end else begin
            f0_d = f1_q;
            f1_d = pdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      upl_q   <= 1'b0;
      hcnt_q  <= '0;
      fcnt_q  <= '0;
      addr_q  <= BASE_ADDR;
      und_q   <= 1'b0;
      hold_q  <= 1'b0;
      f0_q    <= '0;
      f1_q    <= '0;
      cnt_q   <= '0;
`ifdef ACE_UPLOAD_CKSUM_EN
      ck_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      upl_q   <= bus.ioctl_upload;
      hcnt_q  <= hcnt_d;
      fcnt_q  <= fcnt_d;
      addr_q  <= addr_d;
      und_q   <= und_d;
      hold_q  <= hold_d;
      f0_q    <= f0_d;
      f1_q    <= f1_d;
      cnt_q   <= cnt_d;
`ifdef ACE_UPLOAD_CKSUM_EN
      ck_q    <= ck_d;
`endif
    end
  end

  assign bus.ioctl_din = empty ? 8'hFF : f0_q;
  assign bus.mem_rd    = (state_q == WAIT_ACK);
  assign bus.mem_addr  = addr_q;
  assign cpu_hold      = hold_q;
  assign busy          = (state_q != IDLE);
  assign underrun      = und_q;

endmodule

// File: tb/tb_ace_mem_uploader.sv
// Directed bench for ace_mem_uploader.
// Two DUTs: base 2000/len 4 and base FFFE/len 16.
module tb_ace_mem_uploader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hold0, busy0, und0;
  logic hold1, busy1, und1;

  ace_mem_uploader_if b0 ();
  ace_mem_uploader_if b1 ();

  ace_mem_uploader #(
    .BASE_ADDR(16'h2000), .LENGTH(16'd4), .HOLD_CYCLES(8)
  ) u0 (
    .clk_sys(clk), .reset_n(rst_n), .bus(b0),
    .cpu_hold(hold0), .busy(busy0), .underrun(und0)
  );

  ace_mem_uploader #(
    .BASE_ADDR(16'hFFFE), .LENGTH(16'd16), .HOLD_CYCLES(8)
  ) u1 (
    .clk_sys(clk), .reset_n(rst_n), .bus(b1),
    .cpu_hold(hold1), .busy(busy1), .underrun(und1)
  );

  always #5 clk = ~clk;

`ifdef ACE_UPLOAD_CKSUM_EN
  localparam int NB0 = 5;
`else
  localparam int NB0 = 4;
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory models: data = addr[7:0] ^ 5A, ack after latN cycles.
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int lat0 = 1, lat1 = 1;
  int c0 = 0, c1 = 0;
  bit p0 = 0, p1 = 0;

  initial begin
    b0.ioctl_upload = 1'b0; b0.ioctl_rd = 1'b0;
    b0.mem_ack = 1'b0; b0.mem_data = 8'h00;
    b1.ioctl_upload = 1'b0; b1.ioctl_rd = 1'b0;
    b1.mem_ack = 1'b0; b1.mem_data = 8'h00;
  end

  always @(negedge clk) begin
    b0.mem_ack = 1'b0;
    if (!p0 && b0.mem_rd) begin
      p0 = 1; c0 = lat0; q0.push_back(b0.mem_addr);
    end
    if (p0) begin
      c0--;
      if (c0 == 0) begin
        b0.mem_ack = 1'b1;
        b0.mem_data = b0.mem_addr[7:0] ^ 8'h5A;
        p0 = 0;
      end
    end
  end

  always @(negedge clk) begin
    b1.mem_ack = 1'b0;
    if (!p1 && b1.mem_rd) begin
      p1 = 1; c1 = lat1; q1.push_back(b1.mem_addr);
    end
    if (p1) begin
      c1--;
      if (c1 == 0) begin
        b1.mem_ack = 1'b1;
        b1.mem_data = b1.mem_addr[7:0] ^ 8'h5A;
        p1 = 0;
      end
    end
  end

  task automatic rd(int s, output logic [7:0] d);
    @(negedge clk);
    if (s == 0) begin
      d = b0.ioctl_din; b0.ioctl_rd = 1'b1;
    end else begin
      d = b1.ioctl_din; b1.ioctl_rd = 1'b1;
    end
    @(negedge clk);
    b0.ioctl_rd = 1'b0;
    b1.ioctl_rd = 1'b0;
  endtask

  task automatic wait_mrd(string tag, int s, logic v,
                          int bound, output int n);
    n = 0;
    while (((s == 0) ? b0.mem_rd : b1.mem_rd) !== v
           && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < bound), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=done");
    $fatal(1, "timeout");
  end

  logic [7:0] d;
  logic [7:0] got[$];
  logic [7:0] exp0[5];
  int n;

  initial begin
    exp0[0] = 8'h5A; exp0[1] = 8'h5B;
    exp0[2] = 8'h58; exp0[3] = 8'h59;
    exp0[4] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_din", 32'(b0.ioctl_din), 32'hFF);
    check("rst_hold", 32'(hold0), 32'd0);
    check("rst_mrd", 32'(b0.mem_rd), 32'd0);
    check("rst_addr", 32'(b0.mem_addr), 32'h2000);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_und", 32'(und0), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic session, LENGTH=4
    b0.ioctl_upload = 1'b1;
    @(negedge clk);
    check("t1_hold", 32'(hold0), 32'd1);
    check("t1_busy", 32'(busy0), 32'd1);
    wait_mrd("t1_wait_rd", 0, 1'b1, 30, n);
    check("t1_holdlen", 32'(n >= 8), 32'd1);
    check("t1_addr", 32'(b0.mem_addr), 32'h2000);
    repeat (20) @(negedge clk);
    check("t1_prefetch2", 32'(q0.size()), 32'd2);
    for (int i = 0; i < NB0; i++) begin
      rd(0, d);
      check("t1_byte", 32'(d), 32'(exp0[i]));
      repeat (3) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    rd(0, d);
    check("t1_past_end", 32'(d), 32'hFF);
    check("t1_und", 32'(und0), 32'd0);
    check("t1_busy_drain", 32'(busy0), 32'd1);
    check("t1_nfetch", 32'(q0.size()), 32'd4);
    @(negedge clk);
    b0.ioctl_upload = 1'b0;
    @(negedge clk);
    check("t1_idle", 32'(busy0), 32'd0);
    check("t1_hold_lag", 32'(hold0), 32'd1);
    @(negedge clk);
    check("t1_hold_off", 32'(hold0), 32'd0);

    // Slow memory, host reads every cycle
    q0.delete();
    lat0 = 5;
    b0.ioctl_upload = 1'b1;
    wait_mrd("t2_wait_rd", 0, 1'b1, 30, n);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      d = b0.ioctl_din;
      if (d !== 8'hFF) got.push_back(d);
      b0.ioctl_rd = 1'b1;
    end
    @(negedge clk);
    b0.ioctl_rd = 1'b0;
    check("t2_und", 32'(und0), 32'd1);
    check("t2_count", 32'(got.size()), 32'(NB0));
    for (int i = 0; i < NB0; i++)
      check("t2_byte", 32'(got[i]), 32'(exp0[i]));
    b0.ioctl_upload = 1'b0;
    repeat (3) @(negedge clk);

    // Stall and address wrap, no host reads
    lat1 = 1;
    b1.ioctl_upload = 1'b1;
    repeat (40) @(negedge clk);
    check("t3_stall_n", 32'(q1.size()), 32'd2);
    check("t3_stall_rd", 32'(b1.mem_rd), 32'd0);
    check("t3_a0", 32'(q1[0]), 32'hFFFE);
    check("t3_a1", 32'(q1[1]), 32'hFFFF);
    rd(1, d);
    check("t3_d0", 32'(d), 32'hA4);
    repeat (10) @(negedge clk);
    check("t3_n3", 32'(q1.size()), 32'd3);
    check("t3_a2", 32'(q1[2]), 32'h0000);
    rd(1, d);
    check("t3_d1", 32'(d), 32'hA5);
    repeat (10) @(negedge clk);
    check("t3_a3", 32'(q1[3]), 32'h0001);
    check("t3_stall_rd2", 32'(b1.mem_rd), 32'd0);
    b1.ioctl_upload = 1'b0;
    repeat (3) @(negedge clk);
    check("t3_flush", 32'(b1.ioctl_din), 32'hFF);
    check("t3_hold_off", 32'(hold1), 32'd0);
    check("t3_und", 32'(und1), 32'd0);

    // Abort with an outstanding request
    q0.delete();
    lat0 = 10;
    b0.ioctl_upload = 1'b1;
    wait_mrd("t4_wait_rd", 0, 1'b1, 30, n);
    repeat (2) @(negedge clk);
    b0.ioctl_upload = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_rd_held", 32'(b0.mem_rd), 32'd1);
    check("t4_busy_wait", 32'(busy0), 32'd1);
    wait_mrd("t4_wait_ack", 0, 1'b0, 20, n);
    check("t4_idle", 32'(busy0), 32'd0);
    @(negedge clk);
    check("t4_hold_off", 32'(hold0), 32'd0);
    check("t4_flush", 32'(b0.ioctl_din), 32'hFF);
    repeat (5) @(negedge clk);
    q0.delete();
    lat0 = 1;
    b0.ioctl_upload = 1'b1;
    wait_mrd("t4_wait_rd2", 0, 1'b1, 30, n);
    check("t4_restart", 32'(b0.mem_addr), 32'h2000);
    repeat (10) @(negedge clk);
    rd(0, d);
    check("t4_first", 32'(d), 32'h5A);

    // Async reset mid-transfer
    lat0 = 10;
    wait_mrd("t5_wait_rd", 0, 1'b1, 30, n);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rd_drop", 32'(b0.mem_rd), 32'd0);
    check("t5_busy", 32'(busy0), 32'd0);
    check("t5_hold", 32'(hold0), 32'd0);
    check("t5_din", 32'(b0.ioctl_din), 32'hFF);
    b0.ioctl_upload = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
